lane_feedback_mux: RTL and testbench

- Parametrised successor to the single-bit gate/flip-flop/2:1-mux feedback cell. Processes WIDTH independent bit-lanes in parallel.
- Per lane:
  - h = NOR(a,b), g = XOR(b,c), n = NAND(c,d).
  - A registered select picks g (sel=1) or h (sel=0) as output f.
  - The select register's next value comes from feedback, j = n | f, or from a mode-controlled override.
- Adds synchronous reset, enable, select load/hold/clear modes, optional output register, and a saturating select-change counter.
- No combinational loop exists: f depends only on inputs and the registered select.

---
 rtl/lane_feedback_mux.sv | 101 ++++++++++
 tb/tb_lane_feedback_mux.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lane_feedback_mux.sv
// WIDTH-lane gate/mux feedback cell: per-lane NOR/XOR/NAND terms, a registered
// select choosing between them, and a saturating count of select changes.
module lane_feedback_mux #(
   parameter int WIDTH   = 8,
   parameter int OUT_REG = 1,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_cnt,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] f,
   output logic             f_vld,
   output logic [WIDTH-1:0] sel,
   output logic [CNT_W-1:0] chg_cnt
);

   localparam logic [1:0] MODE_FB    = 2'b00;
   localparam logic [1:0] MODE_HOLD  = 2'b01;
   localparam logic [1:0] MODE_LOAD  = 2'b10;
   localparam logic [1:0] MODE_CLEAR = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] h, g, n, f_comb;
   logic [WIDTH-1:0] sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q;

   // Stage p0: lane terms and mux; f_comb only sees the registered select, so no loop
   always_comb begin
      h      = ~(a | b);
      g      = b ^ c;
      n      = ~(c & d);
      f_comb = (sel_q & g) | (~sel_q & h);
   end

   always_comb begin
      sel_d = sel_q;
      case (mode)
         MODE_FB:    sel_d = n | f_comb;
         MODE_HOLD:  sel_d = sel_q;
         MODE_LOAD:  sel_d = load_val;
         MODE_CLEAR: sel_d = '0;
         default:    sel_d = sel_q;
      endcase
   end

   // Stage p1: select and change counter
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q <= '0;
      end else if (en) begin
         sel_q <= sel_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr_cnt) begin
         cnt_q <= '0;
      end else if (en && (sel_d != sel_q) && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign sel     = sel_q;
   assign chg_cnt = cnt_q;

   generate
      if (OUT_REG != 0) begin : gen_oreg
         logic [WIDTH-1:0] f_p1;
         logic             vld_p1;

         always_ff @(posedge clk) begin
            if (rst) begin
               f_p1   <= '0;
               vld_p1 <= 1'b0;
            end else begin
               vld_p1 <= en;
               if (en) begin
                  f_p1 <= f_comb;
               end
            end
         end

         assign f     = f_p1;
         assign f_vld = vld_p1;
      end else begin : gen_ocomb
         assign f     = f_comb;
         assign f_vld = en & ~rst;
      end
   endgenerate

endmodule

// File: tb/tb_lane_feedback_mux.sv
// Directed bench for lane_feedback_mux: registered-output instance plus a
// combinational-output instance sharing the same stimulus.
module tb_lane_feedback_mux;

   logic       clk = 1'b0;
   logic       rst, en, clr_cnt;
   logic [1:0] mode;
   logic [3:0] load_val, a, b, c, d;
   logic [3:0] f0, sel0, f1, sel1;
   logic       vld0, vld1;
   logic [1:0] cnt0, cnt1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lane_feedback_mux #(.WIDTH(4), .OUT_REG(1), .CNT_W(2)) dut_reg (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load_val(load_val),
      .clr_cnt(clr_cnt), .a(a), .b(b), .c(c), .d(d),
      .f(f0), .f_vld(vld0), .sel(sel0), .chg_cnt(cnt0)
   );

   lane_feedback_mux #(.WIDTH(4), .OUT_REG(0), .CNT_W(2)) dut_comb (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load_val(load_val),
      .clr_cnt(clr_cnt), .a(a), .b(b), .c(c), .d(d),
      .f(f1), .f_vld(vld1), .sel(sel1), .chg_cnt(cnt1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      en = 1'b0; mode = 2'b10; load_val = 4'b1111; clr_cnt = 1'b0;
      a = 4'b0; b = 4'b0; c = 4'b0; d = 4'b0;
      do_reset();
      n_cmp++; if (sel0 !== 4'b0000) begin n_bad++; $display("FAIL reset_sel got %b want 0000", sel0); end
      n_cmp++; if (f0 !== 4'b0000) begin n_bad++; $display("FAIL reset_f got %b want 0000", f0); end
      n_cmp++; if (vld0 !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", vld0); end
      n_cmp++; if (cnt0 !== 2'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", cnt0); end
   endtask

   task automatic test_zero_feedback();
      en = 1'b0; mode = 2'b00; a = 4'b0; b = 4'b0; c = 4'b0; d = 4'b0;
      do_reset();
      en = 1'b1;
      tick();
      n_cmp++; if (sel0 !== 4'b1111) begin n_bad++; $display("FAIL zero_e1_sel got %b want 1111", sel0); end
      n_cmp++; if (f0 !== 4'b1111) begin n_bad++; $display("FAIL zero_e1_f got %b want 1111", f0); end
      n_cmp++; if (cnt0 !== 2'd1) begin n_bad++; $display("FAIL zero_e1_cnt got %0d want 1", cnt0); end
      n_cmp++; if (vld0 !== 1'b1) begin n_bad++; $display("FAIL zero_e1_vld got %b want 1", vld0); end
      tick();
      n_cmp++; if (f0 !== 4'b0000) begin n_bad++; $display("FAIL zero_e2_f got %b want 0000", f0); end
      n_cmp++; if (sel0 !== 4'b1111) begin n_bad++; $display("FAIL zero_e2_sel got %b want 1111", sel0); end
      n_cmp++; if (cnt0 !== 2'd1) begin n_bad++; $display("FAIL zero_e2_cnt got %0d want 1", cnt0); end
   endtask

   task automatic test_mixed_feedback();
      en = 1'b0; mode = 2'b00;
      a = 4'b0000; b = 4'b1010; c = 4'b1100; d = 4'b1111;
      do_reset();
      en = 1'b1;
      tick();
      n_cmp++; if (sel0 !== 4'b0111) begin n_bad++; $display("FAIL mixed_e1_sel got %b want 0111", sel0); end
      n_cmp++; if (f0 !== 4'b0101) begin n_bad++; $display("FAIL mixed_e1_f got %b want 0101", f0); end
      tick();
      n_cmp++; if (f0 !== 4'b0110) begin n_bad++; $display("FAIL mixed_e2_f got %b want 0110", f0); end
      n_cmp++; if (sel0 !== 4'b0111) begin n_bad++; $display("FAIL mixed_e2_sel got %b want 0111", sel0); end
      n_cmp++; if (cnt0 !== 2'd1) begin n_bad++; $display("FAIL mixed_e2_cnt got %0d want 1", cnt0); end
   endtask

   task automatic test_load_hold();
      logic [3:0] pat [3] = '{4'b0110, 4'b1111, 4'b0001};
      en = 1'b0; do_reset();
      en = 1'b1; mode = 2'b10; load_val = 4'b1001;
      tick();
      n_cmp++; if (sel0 !== 4'b1001) begin n_bad++; $display("FAIL load_sel got %b want 1001", sel0); end
      n_cmp++; if (cnt0 !== 2'd1) begin n_bad++; $display("FAIL load_cnt got %0d want 1", cnt0); end
      mode = 2'b01; load_val = 4'b0110;
      for (int i = 0; i < 3; i++) begin
         a = pat[i]; b = ~pat[i]; c = pat[i] ^ 4'b0101; d = pat[i];
         tick();
         n_cmp++; if (sel0 !== 4'b1001) begin n_bad++; $display("FAIL hold_sel[%0d] got %b want 1001", i, sel0); end
         n_cmp++; if (cnt0 !== 2'd1) begin n_bad++; $display("FAIL hold_cnt[%0d] got %0d want 1", i, cnt0); end
      end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      logic [3:0] exp_sel;
      en = 1'b0; do_reset();
      en = 1'b1; load_val = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         mode = (i % 2 == 0) ? 2'b10 : 2'b11;
         exp_sel = (i % 2 == 0) ? 4'b1111 : 4'b0000;
         tick();
         n_cmp++; if (sel0 !== exp_sel) begin n_bad++; $display("FAIL sat_sel[%0d] got %b want %b", i, sel0, exp_sel); end
         n_cmp++; if (cnt0 !== exp_cnt[i]) begin n_bad++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, cnt0, exp_cnt[i]); end
      end
      mode = 2'b11; clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      n_cmp++; if (sel0 !== 4'b0000) begin n_bad++; $display("FAIL clrpri_sel got %b want 0000", sel0); end
      n_cmp++; if (cnt0 !== 2'd0) begin n_bad++; $display("FAIL clrpri_cnt got %0d want 0", cnt0); end
   endtask

   task automatic test_enable_reset();
      en = 1'b0; do_reset();
      // Load with all-zero operands: f registers h = 1111 from sel 0000.
      en = 1'b1; mode = 2'b10; load_val = 4'b0110;
      a = 4'b0; b = 4'b0; c = 4'b0; d = 4'b0;
      tick();
      n_cmp++; if (sel0 !== 4'b0110) begin n_bad++; $display("FAIL en_pre_sel got %b want 0110", sel0); end
      n_cmp++; if (f0 !== 4'b1111) begin n_bad++; $display("FAIL en_pre_f got %b want 1111", f0); end
      en = 1'b0; load_val = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         a = 4'(i); b = 4'(3 * i + 1); c = 4'(5 * i); d = 4'b1010;
         mode = 2'(i);
         tick();
         n_cmp++; if (sel0 !== 4'b0110) begin n_bad++; $display("FAIL en0_sel[%0d] got %b want 0110", i, sel0); end
         n_cmp++; if (f0 !== 4'b1111) begin n_bad++; $display("FAIL en0_f[%0d] got %b want 1111", i, f0); end
         n_cmp++; if (cnt0 !== 2'd1) begin n_bad++; $display("FAIL en0_cnt[%0d] got %0d want 1", i, cnt0); end
         n_cmp++; if (vld0 !== 1'b0) begin n_bad++; $display("FAIL en0_vld[%0d] got %b want 0", i, vld0); end
      end
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      n_cmp++; if (cnt0 !== 2'd0) begin n_bad++; $display("FAIL en0_clr_cnt got %0d want 0", cnt0); end
      n_cmp++; if (sel0 !== 4'b0110) begin n_bad++; $display("FAIL en0_clr_sel got %b want 0110", sel0); end
      // Re-arm counter and output, then reset with en=0 / mode=10.
      en = 1'b1; mode = 2'b10; load_val = 4'b1001;
      tick();
      n_cmp++; if (cnt0 !== 2'd1) begin n_bad++; $display("FAIL rearm_cnt got %0d want 1", cnt0); end
      en = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (sel0 !== 4'b0000) begin n_bad++; $display("FAIL rst_sel got %b want 0000", sel0); end
      n_cmp++; if (f0 !== 4'b0000) begin n_bad++; $display("FAIL rst_f got %b want 0000", f0); end
      n_cmp++; if (cnt0 !== 2'd0) begin n_bad++; $display("FAIL rst_cnt got %0d want 0", cnt0); end
      n_cmp++; if (vld0 !== 1'b0) begin n_bad++; $display("FAIL rst_vld got %b want 0", vld0); end
   endtask

   task automatic test_comb_variant();
      en = 1'b1; mode = 2'b00; rst = 1'b1;
      a = 4'b0000; b = 4'b1010; c = 4'b1100; d = 4'b1111;
      #1;
      n_cmp++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL comb_vld_rst got %b want 0", vld1); end
      tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (f1 !== 4'b0101) begin n_bad++; $display("FAIL comb_pre_f got %b want 0101", f1); end
      n_cmp++; if (vld1 !== 1'b1) begin n_bad++; $display("FAIL comb_pre_vld got %b want 1", vld1); end
      tick();
      n_cmp++; if (sel1 !== 4'b0111) begin n_bad++; $display("FAIL comb_e1_sel got %b want 0111", sel1); end
      n_cmp++; if (f1 !== 4'b0110) begin n_bad++; $display("FAIL comb_e1_f got %b want 0110", f1); end
      n_cmp++; if (cnt1 !== 2'd1) begin n_bad++; $display("FAIL comb_e1_cnt got %0d want 1", cnt1); end
      en = 1'b0;
      #1;
      n_cmp++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL comb_en0_vld got %b want 0", vld1); end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 2'b00; load_val = 4'b0; clr_cnt = 1'b0;
      a = 4'b0; b = 4'b0; c = 4'b0; d = 4'b0;
      #2;
      test_reset();
      test_zero_feedback();
      test_mixed_feedback();
      test_load_hold();
      test_saturation();
      test_enable_reset();
      test_comb_variant();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
